fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the main decoder.
- Holds the fetch PC, requests instruction words from instruction memory, and captures each word into an instruction register.
- Presents the captured word to the decoder: 4-bit opcode in the top bits, plus PC and PC+1 for branch/jump target logic.
- Applies redirects (taken BEQ, B) from the datapath and holds its output while the downstream stage stalls.

---
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: two-state instruction fetch stage (fetch, then issue) feeding the main decoder.
// Optional feature macro FETCH_CNT_EN adds a saturating consumed-instruction counter (fetch_count).
module fetch_unit #(
    parameter int unsigned       PC_W     = 8,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         op,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pcplus1,
    output logic               instr_valid
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    state_e               state_q;
    logic [PC_W-1:0]      fpc_q;
    logic [PC_W-1:0]      pc_q;
    logic [INSTR_W-1:0]   instr_q;

    // Redirect outranks both a same-cycle ack and a held (stalled) instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            fpc_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else if (redirect) begin
            state_q <= S_FETCH;
            fpc_q   <= redirect_pc;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        pc_q    <= fpc_q;
                        fpc_q   <= fpc_q + PC_W'(1);
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req    = (state_q == S_FETCH) && !reset;
    assign imem_addr   = fpc_q;
    assign instr       = instr_q;
    assign op          = instr_q[INSTR_W-1 -: 4];
    assign pc          = pc_q;
    assign pcplus1     = pc_q + PC_W'(1);
    assign instr_valid = (state_q == S_ISSUE);

`ifdef FETCH_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_ISSUE) && !stall && !redirect && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic against a
// transaction-level model; also checks fetch_count when FETCH_CNT_EN is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [7:0]  pc;
    logic [7:0]  pcplus1;
    logic        instr_valid;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_count;
`endif

    fetch_unit #(
        .PC_W     (8),
        .INSTR_W  (16),
        .RESET_PC (8'h10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .op          (op),
        .pc          (pc),
        .pcplus1     (pcplus1),
        .instr_valid (instr_valid)
`ifdef FETCH_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    logic [15:0] mem [256];

    // Model: either waiting for a word at m_fpc, or holding m_instr/m_pc for the decoder.
    bit          m_fetch;
    logic [7:0]  m_fpc;
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    int          m_cnt;
    int unsigned wait_cfg;
    int unsigned wait_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch  = 1'b1;
        m_fpc    = 8'h10;
        m_pc     = 8'h10;
        m_instr  = '0;
        m_cnt    = 0;
        wait_cnt = wait_cfg;
    endtask

    // One clock cycle: apply inputs, let the memory respond, check, advance model.
    task automatic step(input bit rst, input bit stl, input bit rdr, input logic [7:0] rpc);
        bit exp_req;
        bit ack;
        reset       = rst;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
        ack        = imem_req && (wait_cnt == 0);
        imem_ack   = ack;
        imem_rdata = ack ? mem[imem_addr] : 16'($urandom);
        #1;
        exp_req = !rst && m_fetch;
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", {24'd0, imem_addr}, {24'd0, m_fpc});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, !m_fetch});
        check("instr", {16'd0, instr}, {16'd0, m_instr});
        check("op", {28'd0, op}, {28'd0, m_instr[15:12]});
        check("pc", {24'd0, pc}, {24'd0, m_pc});
        check("pcplus1", {24'd0, pcplus1}, {24'd0, 8'(m_pc + 8'd1)});
`ifdef FETCH_CNT_EN
        check("fetch_count", {16'd0, fetch_count}, 32'(m_cnt));
`endif
        if (rst) begin
            model_reset();
        end else if (rdr) begin
            m_fpc    = rpc;
            m_fetch  = 1'b1;
            wait_cnt = wait_cfg;
        end else if (m_fetch) begin
            if (wait_cnt == 0) begin
                m_instr  = mem[m_fpc];
                m_pc     = m_fpc;
                m_fpc    = m_fpc + 8'd1;
                m_fetch  = 1'b0;
                wait_cnt = wait_cfg;
            end else begin
                wait_cnt--;
            end
        end else if (!stl) begin
            m_fetch = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h10] = 16'h3123;
        mem[8'h12] = 16'hF040;
        mem[8'h14] = 16'hC045;
        wait_cfg = 0;
        model_reset();

        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset held, then first zero-wait fetch at RESET_PC
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_op", {28'd0, op}, 32'h3);
        check("first_pc", {24'd0, pc}, 32'h10);
        check("first_pcplus1", {24'd0, pcplus1}, 32'h11);

        // Sequential fetch 0x11..0x13
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 8'h00);
            check("seq_gap", {31'd0, instr_valid}, 32'd0);
            step(0, 0, 0, 8'h00);
            check("seq_pc", {24'd0, pc}, 32'(8'h10 + i));
        end

        // Stall on 0xC045 for three cycles
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            check("stall_instr", {16'd0, instr}, 32'hC045);
            check("stall_op", {28'd0, op}, 32'hC);
            check("stall_pc", {24'd0, pc}, 32'h14);
        end
        step(0, 0, 0, 8'h00);
        check("stall_release", {31'd0, instr_valid}, 32'd0);

        // Two wait cycles before ack
        wait_cfg = 2;
        wait_cnt = 2;
        step(0, 0, 0, 8'h00);
        check("wait1_valid", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 0, 8'h00);
        check("wait2_valid", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 0, 8'h00);
        check("wait_done_valid", {31'd0, instr_valid}, 32'd1);
        check("wait_done_pc", {24'd0, pc}, 32'h15);
        wait_cfg = 0;
        wait_cnt = 0;
        step(0, 0, 0, 8'h00);

        // Redirect coinciding with the ack for 0x12
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h40);
        check("redir_drop_valid", {31'd0, instr_valid}, 32'd0);
        check("redir_drop_pc", {24'd0, pc}, 32'h11);
        step(0, 0, 0, 8'h00);
        check("redir_pc", {24'd0, pc}, 32'h40);

        // Wrap-around at 0xFF
        step(0, 0, 1, 8'hFF);
        step(0, 0, 0, 8'h00);
        check("wrap_pc", {24'd0, pc}, 32'hFF);
        check("wrap_pcplus1", {24'd0, pcplus1}, 32'h00);
        step(0, 0, 0, 8'h00);
        check("wrap_addr", {24'd0, imem_addr}, 32'h00);

        // Five consumed plus one redirect-dropped instruction
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 8'h00);
            step(0, 0, 0, 8'h00);
        end
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h20);
`ifdef FETCH_CNT_EN
        check("count_five", {16'd0, fetch_count}, 32'd5);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wait_cfg = $urandom_range(0, 3);
            step(($urandom % 100) == 0, ($urandom % 3) == 0,
                 ($urandom % 20) == 0, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
